// File: rtl/truth_table_sweeper.sv
//-----------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus sequencer for a combinational N_IN-input / N_OUT-output
// block. On an accepted start it walks dut_in through 0 .. 2^N_IN-1. Each
// vector is held for SETTLE+1 cycles, and the response is captured in the last
// of those cycles into a packed truth table.
//
// Parameters:
//   N_IN    number of inputs of the block under test
//   N_OUT   number of outputs captured per vector
//   SETTLE  cycles dut_in is held before the capture cycle (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      sweep request, sampled only while idle
//   dut_in     vector driven to the block under test (MSB = first input)
//   dut_out    response of the block under test
//   busy       high while settling or capturing
//   done       one-cycle pulse after the final capture
//   table_out  captured table; slice [i*N_OUT +: N_OUT] = response to vector i
//
// Optional feature (macro SWEEP_EXPECT_CHECK_EN):
//   expected_table  reference table, same layout as table_out
//   mismatch_cnt    number of vectors whose response differed
//   first_fail      lowest vector index that differed
//   pass            set once the sweep finishes, high when nothing differed
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module truth_table_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [N_IN-1:0]                dut_in,
    input  logic [N_OUT-1:0]               dut_out,
    output logic                           busy,
    output logic                           done,
    output logic [N_OUT*(1<<N_IN)-1:0]     table_out
`ifdef SWEEP_EXPECT_CHECK_EN
    ,
    input  logic [N_OUT*(1<<N_IN)-1:0]     expected_table,
    output logic [N_IN:0]                  mismatch_cnt,
    output logic [N_IN-1:0]                first_fail,
    output logic                           pass
`endif
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned IW    = N_IN + 1;
    localparam int unsigned CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(N_VEC - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_ST,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            accept;

    assign accept = (state == IDLE) && start;

    // State register, plus busy/done registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = SETTLE_ST;
            SETTLE_ST: if (cnt == SETTLE_END) state_nxt = CAPTURE;
            CAPTURE:   state_nxt = (idx == LAST_IDX) ? DONE : SETTLE_ST;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode (from next state, registered above)
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        unique case (state_nxt)
            SETTLE_ST: busy_nxt = 1'b1;
            CAPTURE:   busy_nxt = 1'b1;
            DONE:      done_nxt = 1'b1;
            default: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
            end
        endcase
    end

    // Sweep datapath: vector index, settle counter, stimulus and table.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            table_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx       <= '0;
                        cnt       <= '0;
                        dut_in    <= '0;
                        table_out <= '0;
                    end
                end
                SETTLE_ST: begin
                    if (cnt != SETTLE_END) cnt <= cnt + 1'b1;
                end
                CAPTURE: begin
                    table_out[idx*N_OUT +: N_OUT] <= dut_out;
                    // idx is one bit wider than dut_in so the last-vector
                    // compare never aliases; dut_in stops at N_VEC-1.
                    if (idx != LAST_IDX) begin
                        idx    <= idx + 1'b1;
                        dut_in <= idx[N_IN-1:0] + 1'b1;
                        cnt    <= '0;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

`ifdef SWEEP_EXPECT_CHECK_EN
    logic mismatch;

    assign mismatch = (state == CAPTURE) &&
                      (dut_out != expected_table[idx*N_OUT +: N_OUT]);

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            mismatch_cnt <= '0;
            first_fail   <= '0;
            pass         <= 1'b0;
        end else begin
            if (mismatch) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (mismatch_cnt == '0) first_fail <= idx[N_IN-1:0];
            end
            // Count is final by the time DONE is reached.
            if (state == DONE) pass <= (mismatch_cnt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps

module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Instance A: default parameters
    logic        start_a = 1'b0;
    logic [3:0]  dut_in_a;
    logic [1:0]  dut_out_a;
    logic        busy_a, done_a;
    logic [31:0] table_a;
    logic [1:0]  lut_a [16];

    // Instance B: SETTLE = 3, response driven by a time-based bench model
    logic        start_b = 1'b0;
    logic [3:0]  dut_in_b;
    logic [1:0]  dut_out_b = 2'b00;
    logic        busy_b, done_b;
    logic [31:0] table_b;
    logic [1:0]  lut_b [16];

`ifdef SWEEP_EXPECT_CHECK_EN
    logic [31:0] expected_a = '0;
    logic [4:0]  mcnt_a, mcnt_b;
    logic [3:0]  ffail_a, ffail_b;
    logic        pass_a, pass_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dut_out_a = lut_a[dut_in_a];

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .dut_in    (dut_in_a),
        .dut_out   (dut_out_a),
        .busy      (busy_a),
        .done      (done_a),
        .table_out (table_a)
`ifdef SWEEP_EXPECT_CHECK_EN
        ,
        .expected_table (expected_a),
        .mismatch_cnt   (mcnt_a),
        .first_fail     (ffail_a),
        .pass           (pass_a)
`endif
    );

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .dut_in    (dut_in_b),
        .dut_out   (dut_out_b),
        .busy      (busy_b),
        .done      (done_b),
        .table_out (table_b)
`ifdef SWEEP_EXPECT_CHECK_EN
        ,
        .expected_table (32'h0),
        .mismatch_cnt   (mcnt_b),
        .first_fail     (ffail_b),
        .pass           (pass_b)
`endif
    );

    // ---------------- reference model helpers ----------------
    function automatic logic [1:0] xor_and_model(input int i);
        logic [3:0] v;
        v = 4'(i);
        return {v[3] ^ v[2], v[1] & v[0]};
    endfunction

    task automatic set_lut_a_xor_and();
        for (int i = 0; i < 16; i++) lut_a[i] = xor_and_model(i);
    endtask

    task automatic set_lut_a_random();
        for (int i = 0; i < 16; i++) lut_a[i] = 2'($urandom);
    endtask

    function automatic logic [31:0] lut_a_table();
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i*2 +: 2] = lut_a[i];
        return t;
    endfunction

    // Drive start for one edge (optionally keep it high); returns 1 time unit
    // after the accepting edge (cycle index k = 0).
    task automatic pulse_start_a(input bit hold);
        start_a = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_a = 1'b0;
    endtask

    // Observe ncyc cycles of instance A, recording done pulses.
    task automatic watch_a(input int ncyc, output int done_k, output int pulses);
        done_k = -1;
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (done_a === 1'b1) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%b want=0", done_a); end
        total++; if (dut_in_a !== 4'h0) begin bad++; $display("FAIL reset_dut_in_a got=%h want=0", dut_in_a); end
        total++; if (table_a !== 32'h0) begin bad++; $display("FAIL reset_table_a got=%h want=0", table_a); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%b want=0", busy_b); end
        total++; if (table_b !== 32'h0) begin bad++; $display("FAIL reset_table_b got=%h want=0", table_b); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy_a got=%b want=0", busy_a); end
    endtask

    task automatic test_basic();
        logic [1:0] want;
        set_lut_a_xor_and();
        pulse_start_a(1'b0);
        for (int k = 0; k <= 33; k++) begin
            total++; if (busy_a !== (k < 32)) begin bad++; $display("FAIL basic_busy k=%0d got=%b want=%b", k, busy_a, (k < 32)); end
            total++; if (done_a !== (k == 32)) begin bad++; $display("FAIL basic_done k=%0d got=%b want=%b", k, done_a, (k == 32)); end
            if (k < 32) begin
                total++; if (dut_in_a !== 4'(k / 2)) begin bad++; $display("FAIL basic_dut_in k=%0d got=%h want=%h", k, dut_in_a, 4'(k / 2)); end
            end
            if (k < 33) begin @(posedge clk); #1; end
        end
        total++; if (table_a !== 32'h40EA_EA40) begin bad++; $display("FAIL basic_table got=%h want=40eaea40", table_a); end
        for (int i = 0; i < 16; i++) begin
            want = xor_and_model(i);
            total++; if (table_a[i*2 +: 2] !== want) begin bad++; $display("FAIL basic_slice v=%0d got=%b want=%b", i, table_a[i*2 +: 2], want); end
        end
    endtask

    task automatic test_settle3();
        int v, p;
        logic [31:0] want;
        for (int i = 0; i < 16; i++) lut_b[i] = 2'($urandom);
        want = '0;
        for (int i = 0; i < 16; i++) want[i*2 +: 2] = lut_b[i];
        dut_out_b = 2'b00;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 0; k <= 66; k++) begin
            v = k / 4;
            p = k % 4;
            if (k < 64) begin
                total++; if (dut_in_b !== 4'(v)) begin bad++; $display("FAIL s3_dut_in k=%0d got=%h want=%h", k, dut_in_b, 4'(v)); end
                total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL s3_busy k=%0d got=%b want=1", k, busy_b); end
                // Correct response only in the 4th cycle of each vector.
                dut_out_b = (p == 3) ? lut_b[v] : ~lut_b[v];
            end else begin
                dut_out_b = 2'b00;
            end
            total++; if (done_b !== (k == 64)) begin bad++; $display("FAIL s3_done k=%0d got=%b want=%b", k, done_b, (k == 64)); end
            if (k < 66) begin @(posedge clk); #1; end
        end
        total++; if (table_b !== want) begin bad++; $display("FAIL s3_table got=%h want=%h", table_b, want); end
    endtask

    task automatic test_start_held();
        int pulses, done_k, first_done;
        set_lut_a_random();
        pulse_start_a(1'b1);
        pulses = 0;
        first_done = -1;
        for (int k = 0; k <= 34; k++) begin
            if (done_a === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = k;
            end
            if (k == 33) begin
                total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL held_idle_busy got=%b want=0", busy_a); end
            end
            if (k == 34) begin
                total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL held_restart_busy got=%b want=1", busy_a); end
                total++; if (table_a !== 32'h0) begin bad++; $display("FAIL held_clear_table got=%h want=0", table_a); end
            end
            if (k < 34) begin @(posedge clk); #1; end
        end
        start_a = 1'b0;
        total++; if (pulses !== 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
        total++; if (first_done !== 32) begin bad++; $display("FAIL held_done_k got=%0d want=32", first_done); end
        // second sweep began at k=34 (its k'=0)
        watch_a(34, done_k, pulses);
        total++; if (done_k !== 32) begin bad++; $display("FAIL held2_done_k got=%0d want=32", done_k); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL held2_pulses got=%0d want=1", pulses); end
        total++; if (table_a !== lut_a_table()) begin bad++; $display("FAIL held2_table got=%h want=%h", table_a, lut_a_table()); end
    endtask

    task automatic test_reset_mid();
        int done_k, pulses;
        set_lut_a_random();
        pulse_start_a(1'b0);
        watch_a(9, done_k, pulses);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done_a); end
        total++; if (dut_in_a !== 4'h0) begin bad++; $display("FAIL rmid_dut_in got=%h want=0", dut_in_a); end
        total++; if (table_a !== 32'h0) begin bad++; $display("FAIL rmid_table got=%h want=0", table_a); end
        watch_a(40, done_k, pulses);
        total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", pulses); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_stay_idle got=%b want=0", busy_a); end
        pulse_start_a(1'b0);
        watch_a(34, done_k, pulses);
        total++; if (done_k !== 32) begin bad++; $display("FAIL rmid_clean_done_k got=%0d want=32", done_k); end
        total++; if (table_a !== lut_a_table()) begin bad++; $display("FAIL rmid_clean_table got=%h want=%h", table_a, lut_a_table()); end
    endtask

    task automatic test_back_to_back();
        int done_k, pulses;
        logic [31:0] first_tbl;
        for (int r = 0; r < 3; r++) begin
            set_lut_a_random();
            first_tbl = lut_a_table();
            pulse_start_a(1'b0);
            watch_a(33, done_k, pulses);
            total++; if (table_a !== first_tbl) begin bad++; $display("FAIL b2b_first_table r=%0d got=%h want=%h", r, table_a, first_tbl); end
            set_lut_a_random();
            if (lut_a_table() == first_tbl) lut_a[0] = ~lut_a[0];
            pulse_start_a(1'b0);
            total++; if (table_a !== 32'h0) begin bad++; $display("FAIL b2b_clear r=%0d got=%h want=0", r, table_a); end
            watch_a(34, done_k, pulses);
            total++; if (done_k !== 32) begin bad++; $display("FAIL b2b_done_k r=%0d got=%0d want=32", r, done_k); end
            total++; if (table_a !== lut_a_table()) begin bad++; $display("FAIL b2b_second_table r=%0d got=%h want=%h", r, table_a, lut_a_table()); end
        end
    endtask

`ifdef SWEEP_EXPECT_CHECK_EN
    task automatic test_expect();
        int done_k, pulses;
        logic [31:0] t;
        set_lut_a_xor_and();
        t = lut_a_table();
        t[5*2 +: 2]  = ~t[5*2 +: 2];
        t[12*2 +: 2] = ~t[12*2 +: 2];
        expected_a = t;
        pulse_start_a(1'b0);
        watch_a(34, done_k, pulses);
        total++; if (mcnt_a !== 5'd2) begin bad++; $display("FAIL exp_mcnt got=%0d want=2", mcnt_a); end
        total++; if (ffail_a !== 4'd5) begin bad++; $display("FAIL exp_first_fail got=%0d want=5", ffail_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL exp_pass got=%b want=0", pass_a); end
        expected_a = lut_a_table();
        pulse_start_a(1'b0);
        watch_a(34, done_k, pulses);
        total++; if (mcnt_a !== 5'd0) begin bad++; $display("FAIL exp_ok_mcnt got=%0d want=0", mcnt_a); end
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL exp_ok_pass got=%b want=1", pass_a); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) begin
            lut_a[i] = 2'b00;
            lut_b[i] = 2'b00;
        end
        test_reset();
        test_basic();
        test_settle3();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
`ifdef SWEEP_EXPECT_CHECK_EN
        test_expect();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
